arp_cache_ctrl: RTL
===================

Name: arp_cache_ctrl

Overview:
- Sits directly downstream of the ARP receive path and upstream of the ARP transmit path.
- Consumes each received-ARP result (sender MAC/IP, opcode, done strobe) and learns it into a small IP→MAC cache.
- Queues an ARP reply whenever a request is received.
- Serves IP→MAC lookups from the UDP transmit side; on a miss it issues broadcast ARP requests with timeout and retry.

Parameters:
- ENTRIES, 4, number of cache entries (power of two).
- IDX_W, 2, log2(ENTRIES).
- TIMEOUT_CYC, 125000000, cycles to wait for an answer after each ARP request (1 s at 125 MHz).
- MAX_RETRY, 3, ARP requests sent per lookup before it fails.
- AGE_CYC, 32'd3750000000, entry lifetime in cycles; used only with ARP_AGING_EN.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- arp_rx_done  in  1  one-cycle strobe: pc_mac, pc_ip and arp_rx_op are valid.
- arp_rx_op  in  1  received opcode: 1 = request, 0 = reply.
- pc_mac  in  48  sender MAC of the received packet.
- pc_ip  in  32  sender IP of the received packet.
- arp_tx_done  in  1  one-cycle strobe: ARP frame fully sent.
- arp_tx_en  out  1  one-cycle strobe that starts an ARP transmission.
- arp_tx_op  out  1  opcode to send: 0 = reply, 1 = request.
- tx_des_mac  out  48  destination MAC for the transmitter.
- tx_des_ip  out  32  destination IP for the transmitter.
- lookup_req  in  1  level signal, held until lookup_ack.
- lookup_ip  in  32  IP to resolve; stable while lookup_req is high.
- lookup_ack  out  1  one-cycle strobe: the lookup is finished.
- lookup_hit  out  1  valid with lookup_ack: 1 = MAC found.
- lookup_mac  out  48  valid with lookup_ack when lookup_hit = 1.
- entry_cnt  out  IDX_W+1  number of valid entries.

Behaviour:
Reset:
- All outputs 0; all entries invalid; round-robin pointer 0; both FSMs idle.

Learning (every arp_rx_done, either opcode):
- If a valid entry holds pc_ip, overwrite its MAC.
- Otherwise write the entry at the round-robin pointer, set it valid, and increment the pointer mod ENTRIES (wraps, evicting the oldest slot).
- The table update is visible on the next cycle.
- entry_cnt saturates at ENTRIES.

Reply queue:
- arp_rx_done with arp_rx_op = 1 latches pc_mac/pc_ip into a single reply slot and sets reply_pend.
- A new request while reply_pend is set overwrites the slot; only the newest is answered.

TX arbiter FSM (states TX_IDLE, TX_BUSY):
- In TX_IDLE, reply_pend has priority over a lookup-issued request.
- Grant actions: drive tx_des_mac/tx_des_ip/arp_tx_op, pulse arp_tx_en for 1 cycle, go to TX_BUSY.
- Request frames use tx_des_mac = 48'hFFFF_FFFF_FFFF and tx_des_ip = lookup_ip.
- A reply grant clears reply_pend.
- tx_des_* and arp_tx_op hold until arp_tx_done, which returns the FSM to TX_IDLE.
- arp_tx_done while in TX_IDLE is ignored.

Lookup FSM (states L_IDLE, L_CMP, L_REQ, L_WAIT, L_ACK):
- L_IDLE → L_CMP when lookup_req = 1; lookup_ip is latched.
- L_CMP: parallel compare against the valid entries.
  - Same-cycle arp_rx_done with pc_ip equal to the latched IP bypasses the table and counts as a hit with pc_mac.
  - Hit → L_ACK (lookup_ack 2 cycles after lookup_req is first seen).
  - Miss → L_REQ, retry count = 0.
- L_REQ: raise the request to the arbiter; once granted, go to L_WAIT with the timer cleared.
- L_WAIT:
  - arp_rx_done with pc_ip equal to the latched IP (either opcode) → L_ACK, hit, MAC = pc_mac.
  - Timer reaching TIMEOUT_CYC−1 → retry+1; if retry+1 < MAX_RETRY go to L_REQ, else L_ACK with miss (lookup_hit = 0, lookup_mac = 0).
  - The timer starts at the grant, not at arp_tx_done.
- L_ACK: 1-cycle lookup_ack → L_IDLE.
  - The requester must drop lookup_req in the cycle after the ack.
  - A re-sampled lookup_req starts a new lookup.
- lookup_req dropping mid-lookup is illegal; the FSM completes regardless.
- rst mid-transmission: arp_tx_en stays low and both FSMs return to idle next cycle. The transmitter is reset by the same rst.

Optional Feature:
- Macro ARP_AGING_EN.
- Defined:
  - Each entry has a 32-bit age counter, cleared on learn/refresh and incremented every cycle.
  - At AGE_CYC−1 the entry becomes invalid and entry_cnt decrements.
  - An expire and a learn of the same entry in one cycle: the learn wins.
- Undefined: no counters; entries persist until evicted or reset.

Decomposition:
- Package arp_pkg:
  - ARP_OP_REQ = 1'b1, ARP_OP_REPLY = 1'b0, BCAST_MAC = 48'hFFFF_FFFF_FFFF.
  - Lookup and TX FSM state enums.
  - Entry struct {valid, ip, mac}.
- One sub-module is natural: arp_cache_mem.
  - Holds the entry array, round-robin pointer, compare/hit logic and optional aging.
  - The top holds both FSMs and the reply slot.

Test Plan:
- Learn then lookup: rx_done, op = 0, ip C0A80102, mac 001122334455; then lookup_req ip C0A80102 → ack 2 cycles later, hit = 1, mac 001122334455, no arp_tx_en.
- Request reply: rx_done, op = 1, ip C0A80103, mac AABBCCDDEEFF → arp_tx_en pulse with op = 0, des_mac AABBCCDDEEFF, des_ip C0A80103; entry_cnt = 1.
- Miss resolved: lookup ip C0A80109 on empty cache → arp_tx_en with op = 1, des_mac FFFFFFFFFFFF; inject reply (ip C0A80109, mac 0A0B0C0D0E0F) after arp_tx_done → ack, hit = 1, mac 0A0B0C0D0E0F.
- Miss failure: TIMEOUT_CYC = 100, no reply → exactly 3 request pulses about 100 cycles apart, then ack with hit = 0.
- Priority and wrap: 5 distinct learns with ENTRIES = 4 → the first IP is evicted, entry_cnt = 4. A request received while a lookup is waiting for grant → the reply is transmitted before the ARP request.
- Reset mid-wait: assert rst during L_WAIT → all outputs 0 and entry_cnt = 0 next cycle; a later lookup misses.

Source files
------------

// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - shared opcodes, broadcast MAC, FSM state enums and cache entry type
package arp_pkg;

    localparam logic        ARP_OP_REQ   = 1'b1;
    localparam logic        ARP_OP_REPLY = 1'b0;
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        L_IDLE,
        L_CMP,
        L_REQ,
        L_WAIT,
        L_ACK
    } lookup_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] ip;
        logic [47:0] mac;
    } arp_entry_t;

endpackage

// File: rtl/arp_cache_mem.sv
// rtl/arp_cache_mem.sv - IP->MAC entry table with round-robin replacement and parallel compare
// ARP_AGING_EN adds a per-entry age counter that invalidates entries after AGE_CYC cycles.
module arp_cache_mem
    import arp_pkg::*;
#(
    parameter int          ENTRIES = 4,
    parameter int          IDX_W   = 2,
    parameter logic [31:0] AGE_CYC = 32'd3750000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             learn_en,
    input  logic [31:0]      learn_ip,
    input  logic [47:0]      learn_mac,
    input  logic [31:0]      cmp_ip,
    output logic             cmp_hit,
    output logic [47:0]      cmp_mac,
    output logic [IDX_W:0]   entry_cnt
);

    arp_entry_t       tbl [ENTRIES];
    logic [IDX_W-1:0] rr_ptr;
    logic             learn_match;
    logic [IDX_W-1:0] learn_idx;

    // Learning never duplicates an IP, so at most one entry can match either port.
    always_comb begin
        learn_match = 1'b0;
        learn_idx   = '0;
        cmp_hit     = 1'b0;
        cmp_mac     = '0;
        entry_cnt   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (tbl[i].valid && tbl[i].ip == learn_ip) begin
                learn_match = 1'b1;
                learn_idx   = IDX_W'(i);
            end
            if (tbl[i].valid && tbl[i].ip == cmp_ip) begin
                cmp_hit = 1'b1;
                cmp_mac = tbl[i].mac;
            end
            entry_cnt = entry_cnt + (IDX_W+1)'(tbl[i].valid);
        end
    end

`ifdef ARP_AGING_EN
    logic [31:0] age [ENTRIES];
`else
    logic unused_age;
    assign unused_age = ^AGE_CYC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '0;
`ifdef ARP_AGING_EN
                age[i] <= '0;
`endif
            end
        end else begin
`ifdef ARP_AGING_EN
            for (int i = 0; i < ENTRIES; i++) begin
                if (tbl[i].valid) begin
                    if (age[i] == AGE_CYC - 32'd1) tbl[i].valid <= 1'b0;
                    age[i] <= age[i] + 32'd1;
                end
            end
`endif
            // Written last so a learn overrides an expiry of the same slot.
            if (learn_en) begin
                if (learn_match) begin
                    tbl[learn_idx] <= '{valid: 1'b1, ip: learn_ip, mac: learn_mac};
`ifdef ARP_AGING_EN
                    age[learn_idx] <= '0;
`endif
                end else begin
                    tbl[rr_ptr] <= '{valid: 1'b1, ip: learn_ip, mac: learn_mac};
                    rr_ptr      <= rr_ptr + 1'b1;
`ifdef ARP_AGING_EN
                    age[rr_ptr] <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: rtl/arp_cache_ctrl.sv
// rtl/arp_cache_ctrl.sv - ARP cache controller: learning, reply queue, TX arbiter and lookup FSM
// Define ARP_AGING_EN to enable entry expiry inside arp_cache_mem.
module arp_cache_ctrl
    import arp_pkg::*;
#(
    parameter int          ENTRIES     = 4,
    parameter int          IDX_W       = 2,
    parameter int          TIMEOUT_CYC = 125000000,
    parameter int          MAX_RETRY   = 3,
    parameter logic [31:0] AGE_CYC     = 32'd3750000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arp_rx_done,
    input  logic             arp_rx_op,
    input  logic [47:0]      pc_mac,
    input  logic [31:0]      pc_ip,
    input  logic             arp_tx_done,
    output logic             arp_tx_en,
    output logic             arp_tx_op,
    output logic [47:0]      tx_des_mac,
    output logic [31:0]      tx_des_ip,
    input  logic             lookup_req,
    input  logic [31:0]      lookup_ip,
    output logic             lookup_ack,
    output logic             lookup_hit,
    output logic [47:0]      lookup_mac,
    output logic [IDX_W:0]   entry_cnt
);

    lookup_state_t l_state, l_next;
    tx_state_t     tx_state, tx_next;

    logic [31:0] lk_ip;
    logic [7:0]  retry;
    logic [7:0]  retry_p1;
    logic [31:0] timer;
    logic        res_hit, res_hit_n, res_load;
    logic [47:0] res_mac, res_mac_n;
    logic        timer_clr, retry_clr, retry_inc;
    logic        reply_pend;
    logic [47:0] reply_mac;
    logic [31:0] reply_ip;
    logic        grant_reply, grant_req;
    logic        cmp_hit;
    logic [47:0] cmp_mac;
    logic        rx_match;

    arp_cache_mem #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .AGE_CYC (AGE_CYC)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .learn_en  (arp_rx_done),
        .learn_ip  (pc_ip),
        .learn_mac (pc_mac),
        .cmp_ip    (lk_ip),
        .cmp_hit   (cmp_hit),
        .cmp_mac   (cmp_mac),
        .entry_cnt (entry_cnt)
    );

    assign rx_match = arp_rx_done && (pc_ip == lk_ip);
    assign retry_p1 = retry + 8'd1;

    always_comb begin
        tx_next     = tx_state;
        grant_reply = 1'b0;
        grant_req   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (reply_pend) begin
                    grant_reply = 1'b1;
                    tx_next     = TX_BUSY;
                end else if (l_state == L_REQ) begin
                    grant_req = 1'b1;
                    tx_next   = TX_BUSY;
                end
            end
            TX_BUSY: if (arp_tx_done) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            arp_tx_en  <= 1'b0;
            arp_tx_op  <= 1'b0;
            tx_des_mac <= '0;
            tx_des_ip  <= '0;
            reply_pend <= 1'b0;
            reply_mac  <= '0;
            reply_ip   <= '0;
        end else begin
            tx_state  <= tx_next;
            arp_tx_en <= grant_reply | grant_req;
            if (grant_reply) begin
                arp_tx_op  <= ARP_OP_REPLY;
                tx_des_mac <= reply_mac;
                tx_des_ip  <= reply_ip;
                reply_pend <= 1'b0;
            end else if (grant_req) begin
                arp_tx_op  <= ARP_OP_REQ;
                tx_des_mac <= BCAST_MAC;
                tx_des_ip  <= lk_ip;
            end
            // A fresh request overrides the grant-clear so only the newest is answered.
            if (arp_rx_done && arp_rx_op == ARP_OP_REQ) begin
                reply_pend <= 1'b1;
                reply_mac  <= pc_mac;
                reply_ip   <= pc_ip;
            end
        end
    end

    always_comb begin
        l_next     = l_state;
        res_load   = 1'b0;
        res_hit_n  = 1'b0;
        res_mac_n  = '0;
        timer_clr  = 1'b0;
        retry_clr  = 1'b0;
        retry_inc  = 1'b0;
        lookup_ack = (l_state == L_ACK);
        lookup_hit = lookup_ack & res_hit;
        lookup_mac = lookup_ack ? res_mac : '0;
        case (l_state)
            L_IDLE: if (lookup_req) l_next = L_CMP;
            L_CMP: begin
                if (rx_match) begin
                    l_next    = L_ACK;
                    res_load  = 1'b1;
                    res_hit_n = 1'b1;
                    res_mac_n = pc_mac;
                end else if (cmp_hit) begin
                    l_next    = L_ACK;
                    res_load  = 1'b1;
                    res_hit_n = 1'b1;
                    res_mac_n = cmp_mac;
                end else begin
                    l_next    = L_REQ;
                    retry_clr = 1'b1;
                end
            end
            L_REQ: begin
                if (grant_req) begin
                    l_next    = L_WAIT;
                    timer_clr = 1'b1;
                end
            end
            L_WAIT: begin
                if (rx_match) begin
                    l_next    = L_ACK;
                    res_load  = 1'b1;
                    res_hit_n = 1'b1;
                    res_mac_n = pc_mac;
                end else if (timer == 32'(TIMEOUT_CYC - 1)) begin
                    if (retry_p1 < 8'(MAX_RETRY)) begin
                        l_next    = L_REQ;
                        retry_inc = 1'b1;
                    end else begin
                        l_next   = L_ACK;
                        res_load = 1'b1;
                    end
                end
            end
            L_ACK:   l_next = L_IDLE;
            default: l_next = L_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_state <= L_IDLE;
            lk_ip   <= '0;
            retry   <= '0;
            timer   <= '0;
            res_hit <= 1'b0;
            res_mac <= '0;
        end else begin
            l_state <= l_next;
            if (l_state == L_IDLE && lookup_req) lk_ip <= lookup_ip;
            if (timer_clr) timer <= '0;
            else if (l_state == L_WAIT) timer <= timer + 32'd1;
            if (retry_clr) retry <= '0;
            else if (retry_inc) retry <= retry_p1;
            if (res_load) begin
                res_hit <= res_hit_n;
                res_mac <= res_mac_n;
            end
        end
    end

endmodule
